// File: rtl/chaser_swarm_obstacle_pkg.sv
// rtl/chaser_swarm_obstacle_pkg.sv - shared field bounds, state encoding and helpers for the chaser swarm
package chaser_swarm_obstacle_pkg;

    // Playable field, inclusive pixel bounds
    localparam logic [11:0] FIELD_TOP    = 12'd317;
    localparam logic [11:0] FIELD_BOTTOM = 12'd617;
    localparam logic [11:0] FIELD_LEFT   = 12'd361;
    localparam logic [11:0] FIELD_RIGHT  = 12'd661;

    // Spawn points sit this far inside the field corners
    localparam logic [11:0] SPAWN_INSET  = 12'd20;

    localparam logic [11:0] COLOR_BLACK  = 12'h000;
    localparam logic [11:0] COLOR_YELLOW = 12'hff0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPAWN = 2'd1,
        ST_CHASE = 2'd2,
        ST_DEATH = 2'd3
    } chaser_state_t;

    // Corner order by idx%4: top-left, bottom-right, top-right, bottom-left
    function automatic logic [11:0] spawn_x(input int idx);
        case (idx % 4)
            0, 3:    return FIELD_LEFT + SPAWN_INSET;
            default: return FIELD_RIGHT - SPAWN_INSET;
        endcase
    endfunction

    function automatic logic [11:0] spawn_y(input int idx);
        case (idx % 4)
            0, 2:    return FIELD_TOP + SPAWN_INSET;
            default: return FIELD_BOTTOM - SPAWN_INSET;
        endcase
    endfunction

    // |px-cx|<=half && |py-cy|<=half, rearranged so nothing is subtracted
    function automatic logic in_square(input logic [11:0] px, input logic [11:0] py,
                                       input logic [11:0] cx, input logic [11:0] cy,
                                       input logic [11:0] half);
        logic x_ok;
        logic y_ok;
        x_ok = (({1'b0, px} + {1'b0, half}) >= {1'b0, cx}) &&
               ({1'b0, px} <= ({1'b0, cx} + {1'b0, half}));
        y_ok = (({1'b0, py} + {1'b0, half}) >= {1'b0, cy}) &&
               ({1'b0, py} <= ({1'b0, cy} + {1'b0, half}));
        return x_ok && y_ok;
    endfunction

endpackage

// File: rtl/chaser_swarm_obstacle_if.sv
// rtl/chaser_swarm_obstacle_if.sv - pixel chain and game control bundle for the chaser swarm
// master: upstream/game side driving pixel position, colour, mouse and control.
// slave:  the obstacle, returning colour, obstacle coordinates, working and done.
interface chaser_swarm_obstacle_if;
    logic [11:0] hcount_in;
    logic [11:0] vcount_in;
    logic [11:0] rgb_in;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        done_control;
    logic [3:0]  selected;
    logic        play_selected;
    logic        menu_on;
    logic [11:0] rgb_out;
    logic [11:0] obstacle_x;
    logic [11:0] obstacle_y;
    logic        working;
    logic        done;

    modport master (
        output hcount_in, vcount_in, rgb_in, mouse_xpos, mouse_ypos,
               done_control, selected, play_selected, menu_on,
        input  rgb_out, obstacle_x, obstacle_y, working, done
    );

    modport slave (
        input  hcount_in, vcount_in, rgb_in, mouse_xpos, mouse_ypos,
               done_control, selected, play_selected, menu_on,
        output rgb_out, obstacle_x, obstacle_y, working, done
    );
endinterface

// File: rtl/chaser_swarm_obstacle_axis.sv
// rtl/chaser_swarm_obstacle_axis.sv - one axis of one enemy: move counter, compare, clamp, step
// Ports: pclk, rst; load/load_pos reseed the position and clear the counter;
// enable lets the axis chase target; pos is the current centre coordinate.
module chaser_axis_step #(
    parameter logic [25:0] DIV = 26'd600000,
    parameter logic [11:0] LO  = 12'd0,
    parameter logic [11:0] HI  = 12'd4095
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        load,
    input  logic [11:0] load_pos,
    input  logic        enable,
    input  logic [11:0] target,
    output logic [11:0] pos
);

    logic [25:0] move_cnt;

    always_ff @(posedge pclk) begin
        if (rst) begin
            pos      <= '0;
            move_cnt <= '0;
        end else if (load) begin
            pos      <= load_pos;
            move_cnt <= '0;
        end else if (enable) begin
            if (pos == target) begin
                move_cnt <= '0;
            end else if (move_cnt == DIV) begin
                // The counter restarts even when the clamp swallows the step
                move_cnt <= '0;
                if (pos < target) begin
                    if (pos < HI) pos <= pos + 12'd1;
                end else begin
                    if (pos > LO) pos <= pos - 12'd1;
                end
            end else begin
                move_cnt <= move_cnt + 26'd1;
            end
        end
    end

endmodule

// File: rtl/chaser_swarm_obstacle.sv
// rtl/chaser_swarm_obstacle.sv - N square enemies that spawn, chase the mouse, then shrink away
// Ports: pclk, rst (sync, active-high); bus (slave): hcount_in/vcount_in/rgb_in pixel in,
// mouse_xpos/ypos, done_control start strobe, selected/play_selected/menu_on control;
// rgb_out, obstacle_x/y, working, done out, all registered.
module chaser_swarm_obstacle
    import chaser_swarm_obstacle_pkg::*;
#(
    parameter int                    N_ENEMY      = 4,
    parameter int                    SIZE_MAX     = 15,
    parameter int                    GROWTH_DIV   = 3200000,
    parameter int                    MOVE_DIV     = 600000,
    parameter int                    TIME_LIMIT   = 650000000,
    parameter logic [3:0]            SELECT_CODE  = 4'b0101,
    parameter logic [12*N_ENEMY-1:0] ENEMY_COLORS = {N_ENEMY{12'hff0}}
) (
    input logic                      pclk,
    input logic                      rst,
    chaser_swarm_obstacle_if.slave   bus
);

    localparam logic [11:0] BORDER_MAX  = 12'(SIZE_MAX);
    localparam logic [11:0] TARGET_OFS  = 12'(SIZE_MAX / 2);
    localparam logic [25:0] GROWTH_LAST = 26'(GROWTH_DIV);
    localparam logic [30:0] TIME_LAST   = 31'(TIME_LIMIT - 1);
    localparam logic [11:0] X_LO        = 12'(FIELD_LEFT + 12'(SIZE_MAX));
    localparam logic [11:0] X_HI        = 12'(FIELD_RIGHT - 12'(SIZE_MAX));
    localparam logic [11:0] Y_LO        = 12'(FIELD_TOP + 12'(SIZE_MAX));
    localparam logic [11:0] Y_HI        = 12'(FIELD_BOTTOM - 12'(SIZE_MAX));

    chaser_state_t state;
    logic [11:0]   border;
    logic [25:0]   growth_cnt;
    logic [30:0]   time_cnt;
    logic          working_q;
    logic          done_q;
    logic [11:0]   rgb_q;
    logic [11:0]   obs_x_q;
    logic [11:0]   obs_y_q;

    logic [11:0]   cx [N_ENEMY];
    logic [11:0]   cy [N_ENEMY];
    logic [11:0]   target_x;
    logic [11:0]   target_y;
    logic          abort;
    logic          load_spawn;
    logic          move_en;
    logic          hit;
    logic [11:0]   hit_color;

    assign abort      = bus.menu_on || !bus.play_selected;
    assign load_spawn = (state == ST_IDLE) && bus.done_control;
    // Enemies freeze on the cycle an abort is taken
    assign move_en    = (state == ST_CHASE) && !abort;
    assign target_x   = bus.mouse_xpos + TARGET_OFS;
    assign target_y   = bus.mouse_ypos + TARGET_OFS;

    for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_enemy
        chaser_axis_step #(
            .DIV (26'(MOVE_DIV / (gi + 1))),
            .LO  (X_LO),
            .HI  (X_HI)
        ) u_x (
            .pclk     (pclk),
            .rst      (rst),
            .load     (load_spawn),
            .load_pos (spawn_x(gi)),
            .enable   (move_en),
            .target   (target_x),
            .pos      (cx[gi])
        );
        chaser_axis_step #(
            .DIV (26'(MOVE_DIV / (gi + 1))),
            .LO  (Y_LO),
            .HI  (Y_HI)
        ) u_y (
            .pclk     (pclk),
            .rst      (rst),
            .load     (load_spawn),
            .load_pos (spawn_y(gi)),
            .enable   (move_en),
            .target   (target_y),
            .pos      (cy[gi])
        );
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= ST_IDLE;
            border     <= '0;
            growth_cnt <= '0;
            time_cnt   <= '0;
            working_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state != ST_IDLE && abort) begin
                state     <= ST_IDLE;
                working_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        working_q <= 1'b0;
                        if (bus.done_control) begin
                            border     <= '0;
                            growth_cnt <= '0;
                            time_cnt   <= '0;
                            if (bus.selected == SELECT_CODE && bus.play_selected) begin
                                state     <= ST_SPAWN;
                                working_q <= 1'b1;
                            end
                        end
                    end
                    ST_SPAWN: begin
                        if (border == BORDER_MAX) begin
                            state <= ST_CHASE;
                        end else if (growth_cnt == GROWTH_LAST) begin
                            growth_cnt <= '0;
                            border     <= border + 12'd1;
                        end else begin
                            growth_cnt <= growth_cnt + 26'd1;
                        end
                    end
                    ST_CHASE: begin
                        // Exactly TIME_LIMIT clocks are spent chasing
                        time_cnt <= time_cnt + 31'd1;
                        if (time_cnt == TIME_LAST) begin
                            state      <= ST_DEATH;
                            growth_cnt <= '0;
                        end
                    end
                    ST_DEATH: begin
                        if (border == '0) begin
                            state     <= ST_IDLE;
                            working_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else if (growth_cnt == GROWTH_LAST) begin
                            growth_cnt <= '0;
                            border     <= border - 12'd1;
                        end else begin
                            growth_cnt <= growth_cnt + 26'd1;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        working_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Scan from the top index down so the lowest overlapping enemy wins
    always_comb begin
        hit       = 1'b0;
        hit_color = COLOR_BLACK;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (in_square(bus.hcount_in, bus.vcount_in, cx[i], cy[i], border)) begin
                hit       = 1'b1;
                hit_color = ENEMY_COLORS[12*i +: 12];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            rgb_q   <= '0;
            obs_x_q <= '0;
            obs_y_q <= '0;
        end else begin
            rgb_q   <= (state != ST_IDLE && hit) ? hit_color : bus.rgb_in;
            obs_x_q <= (state == ST_CHASE && hit) ? bus.hcount_in : 12'd0;
            obs_y_q <= (state == ST_CHASE && hit) ? bus.vcount_in : 12'd0;
        end
    end

    assign bus.rgb_out    = rgb_q;
    assign bus.obstacle_x = obs_x_q;
    assign bus.obstacle_y = obs_y_q;
    assign bus.working    = working_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_chaser_swarm_obstacle.sv
// tb/tb_chaser_swarm_obstacle.sv - randomized bench for chaser_swarm_obstacle against a behavioural model
module tb_chaser_swarm_obstacle;

    localparam int         N   = 4;
    localparam int         SM  = 3;
    localparam int         GD  = 2;
    localparam int         MD  = 4;
    localparam int         TL  = 1000;
    localparam logic [3:0] SEL = 4'b0101;
    localparam logic [47:0] COLS = {12'h444, 12'h333, 12'h222, 12'h111};

    logic pclk = 1'b0;
    logic rst;
    always #5 pclk = ~pclk;

    chaser_swarm_obstacle_if bus ();

    chaser_swarm_obstacle #(
        .N_ENEMY      (N),
        .SIZE_MAX     (SM),
        .GROWTH_DIV   (GD),
        .MOVE_DIV     (MD),
        .TIME_LIMIT   (TL),
        .SELECT_CODE  (SEL),
        .ENEMY_COLORS (COLS)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    int n_vec;
    int n_err;
    int done_seen;
    bit fix_pix;

    // model: 0 idle, 1 growing, 2 chasing, 3 shrinking
    int m_state, m_border, m_gclk, m_tclk;
    int m_cx [N];
    int m_cy [N];
    int m_ex [N];
    int m_ey [N];
    logic [11:0] e_rgb, e_ox, e_oy;
    logic        e_work, e_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic logic [11:0] colour_of(input int i);
        return 12'(12'h111 * (i + 1));
    endfunction

    task automatic move_axis(inout int pos, inout int el, input int tgt,
                             input int lo, input int hi, input int period);
        int np;
        if (pos == tgt) begin
            el = 0;
        end else begin
            el++;
            if (el == period) begin
                el = 0;
                np = (tgt > pos) ? pos + 1 : pos - 1;
                if (np >= lo && np <= hi) pos = np;
            end
        end
    endtask

    task automatic model_step();
        int  h, v, hit_i, p, e;
        bit  abort;
        h = int'(bus.hcount_in);
        v = int'(bus.vcount_in);
        if (rst) begin
            m_state = 0; m_border = 0; m_gclk = 0; m_tclk = 0;
            for (int i = 0; i < N; i++) begin
                m_cx[i] = 0; m_cy[i] = 0; m_ex[i] = 0; m_ey[i] = 0;
            end
            e_rgb = 0; e_ox = 0; e_oy = 0; e_work = 0; e_done = 0;
            return;
        end
        hit_i = -1;
        if (m_state != 0)
            for (int i = 0; i < N; i++)
                if (hit_i < 0 && iabs(h - m_cx[i]) <= m_border && iabs(v - m_cy[i]) <= m_border)
                    hit_i = i;
        e_rgb  = (hit_i >= 0) ? colour_of(hit_i) : bus.rgb_in;
        e_ox   = (hit_i >= 0 && m_state == 2) ? bus.hcount_in : 12'd0;
        e_oy   = (hit_i >= 0 && m_state == 2) ? bus.vcount_in : 12'd0;
        e_done = 1'b0;
        abort  = bus.menu_on || !bus.play_selected;
        if (m_state != 0 && abort) begin
            m_state = 0;
        end else begin
            case (m_state)
                0: if (bus.done_control) begin
                    for (int i = 0; i < N; i++) begin
                        m_cx[i] = (i % 4 == 0 || i % 4 == 3) ? 381 : 641;
                        m_cy[i] = (i % 4 == 0 || i % 4 == 2) ? 337 : 597;
                        m_ex[i] = 0; m_ey[i] = 0;
                    end
                    m_border = 0; m_gclk = 0; m_tclk = 0;
                    if (bus.selected == SEL && bus.play_selected) m_state = 1;
                end
                1: if (m_border == SM) m_state = 2;
                   else begin
                       m_gclk++;
                       if (m_gclk == GD + 1) begin m_gclk = 0; m_border++; end
                   end
                2: begin
                    for (int i = 0; i < N; i++) begin
                        p = m_cx[i]; e = m_ex[i];
                        move_axis(p, e, int'(bus.mouse_xpos) + SM / 2, 361 + SM, 661 - SM, MD / (i + 1) + 1);
                        m_cx[i] = p; m_ex[i] = e;
                        p = m_cy[i]; e = m_ey[i];
                        move_axis(p, e, int'(bus.mouse_ypos) + SM / 2, 317 + SM, 617 - SM, MD / (i + 1) + 1);
                        m_cy[i] = p; m_ey[i] = e;
                    end
                    m_tclk++;
                    if (m_tclk == TL) begin m_state = 3; m_gclk = 0; end
                end
                3: if (m_border == 0) begin m_state = 0; e_done = 1'b1; end
                   else begin
                       m_gclk++;
                       if (m_gclk == GD + 1) begin m_gclk = 0; m_border--; end
                   end
                default: ;
            endcase
        end
        e_work = (m_state != 0);
    endtask

    task automatic cycle();
        int k;
        if (!fix_pix) begin
            k = $urandom_range(N - 1, 0);
            if ($urandom_range(1, 0) == 1 && m_state != 0) begin
                bus.hcount_in = 12'(m_cx[k] + int'($urandom_range(2 * SM + 2, 0)) - (SM + 1));
                bus.vcount_in = 12'(m_cy[k] + int'($urandom_range(2 * SM + 2, 0)) - (SM + 1));
            end else begin
                bus.hcount_in = 12'($urandom_range(700, 340));
                bus.vcount_in = 12'($urandom_range(650, 300));
            end
            bus.rgb_in = 12'($urandom);
        end
        model_step();
        @(posedge pclk);
        #1;
        chk("rgb_out", 32'(bus.rgb_out), 32'(e_rgb));
        chk("obstacle_x", 32'(bus.obstacle_x), 32'(e_ox));
        chk("obstacle_y", 32'(bus.obstacle_y), 32'(e_oy));
        chk("working", 32'(bus.working), 32'(e_work));
        chk("done", 32'(bus.done), 32'(e_done));
        if (bus.done) done_seen++;
        @(negedge pclk);
    endtask

    task automatic run_until(input int st, input int budget, input string tag);
        int n;
        n = 0;
        while (m_state != st && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 32'(m_state == st), 32'd1);
    endtask

    task automatic start_run();
        bus.done_control = 1'b1;
        cycle();
        bus.done_control = 1'b0;
    endtask

    task automatic probe(input logic [11:0] h, input logic [11:0] v, input logic [11:0] c,
                         input string tag, input logic [11:0] exp_rgb,
                         input logic [11:0] exp_x, input logic [11:0] exp_y);
        fix_pix = 1'b1;
        bus.hcount_in = h;
        bus.vcount_in = v;
        bus.rgb_in    = c;
        cycle();
        chk({tag, "_rgb"}, 32'(bus.rgb_out), 32'(exp_rgb));
        chk({tag, "_x"}, 32'(bus.obstacle_x), 32'(exp_x));
        chk({tag, "_y"}, 32'(bus.obstacle_y), 32'(exp_y));
        fix_pix = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_err = 0; done_seen = 0; fix_pix = 1'b0;
        rst = 1'b1;
        bus.hcount_in = 0; bus.vcount_in = 0; bus.rgb_in = 0;
        bus.mouse_xpos = 0; bus.mouse_ypos = 0;
        bus.done_control = 0; bus.selected = 0; bus.play_selected = 0; bus.menu_on = 0;
        @(negedge pclk);
        cycle();
        cycle();
        chk("rst_rgb", 32'(bus.rgb_out), 32'd0);
        chk("rst_working", 32'(bus.working), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        // chase a fixed mouse until the enemies settle, then check overlap priority
        bus.play_selected = 1'b1;
        bus.selected = SEL;
        bus.mouse_xpos = 12'd500;
        bus.mouse_ypos = 12'd450;
        start_run();
        chk("start_working", 32'(bus.working), 32'd1);
        run_until(2, 100, "reach_chase");
        repeat (700) cycle();
        probe(12'd501, 12'd451, 12'h0f0, "overlap", 12'h111, 12'd501, 12'd451);
        probe(12'd504, 12'd451, 12'h0f0, "edge_in", 12'h111, 12'd504, 12'd451);
        probe(12'd505, 12'd451, 12'h0f0, "edge_out", 12'h0f0, 12'd0, 12'd0);

        // reset mid-chase
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("midrst_rgb", 32'(bus.rgb_out), 32'd0);
        chk("midrst_obs_x", 32'(bus.obstacle_x), 32'd0);
        chk("midrst_obs_y", 32'(bus.obstacle_y), 32'd0);
        chk("midrst_working", 32'(bus.working), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        cycle();

        // mouse in the corner: clamp, then time out with one done pulse
        bus.mouse_xpos = 12'd0;
        bus.mouse_ypos = 12'd0;
        done_seen = 0;
        start_run();
        run_until(2, 100, "reach_chase2");
        repeat (200) cycle();
        probe(12'd364, 12'd320, 12'h00f, "clamp", 12'h111, 12'd364, 12'd320);
        probe(12'd360, 12'd320, 12'h00f, "clamp_out", 12'h00f, 12'd0, 12'd0);
        run_until(0, 2000, "timeout_idle");
        chk("done_pulses", 32'(done_seen), 32'd1);

        // random mouse motion with sporadic aborts and stray strobes
        for (int r = 0; r < 4; r++) begin
            start_run();
            for (int c = 0; c < 1500 && m_state != 0; c++) begin
                if (c % 40 == 0) begin
                    bus.mouse_xpos = 12'($urandom_range(700, 300));
                    bus.mouse_ypos = 12'($urandom_range(660, 280));
                end
                bus.menu_on       = ($urandom_range(700, 0) == 0);
                bus.play_selected = ($urandom_range(900, 0) != 0);
                bus.done_control  = ($urandom_range(50, 0) == 0);
                cycle();
            end
            bus.menu_on = 1'b0;
            bus.play_selected = 1'b1;
            bus.done_control = 1'b0;
            cycle();
        end

        // menu abort in DEATH with border already 0 wins over done
        start_run();
        begin
            int n;
            n = 0;
            while (!(m_state == 3 && m_border == 0) && n < 2500) begin
                cycle();
                n++;
            end
            chk("reach_death_b0", 32'(m_state == 3 && m_border == 0), 32'd1);
        end
        done_seen = 0;
        bus.menu_on = 1'b1;
        cycle();
        bus.menu_on = 1'b0;
        repeat (3) cycle();
        chk("abort_done", 32'(done_seen), 32'd0);
        chk("abort_working", 32'(bus.working), 32'd0);

        // wrong selection code never arms
        bus.selected = 4'b0011;
        start_run();
        chk("wrong_sel_working", 32'(bus.working), 32'd0);
        repeat (5) cycle();
        bus.selected = SEL;
        bus.play_selected = 1'b0;
        start_run();
        chk("no_play_working", 32'(bus.working), 32'd0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
